regfile_mp: RTL

Parametrised successor to the pipeline register file: one write port, two registered read ports, configurable data width and register count. Optional hardwired zero register, plus a sequenced bulk-clear engine that wipes the array one entry per cycle. Sits in the ID stage of the pipelined MIPS core. Read data is captured on the same edge that ends ID, so it feeds the ID/EX boundary directly.

---
 rtl/regfile_mp.sv | 100 ++++++++++
 1 files changed

// File: rtl/regfile_mp.sv
// rtl/regfile_mp.sv - two-read/one-write register file with bulk-clear engine
// Optional write-to-read forwarding when REGFILE_BYPASS_EN is defined.
module regfile_mp #(
    parameter int DATA_W   = 32,
    parameter int ADDR_W   = 5,
    parameter int ZERO_REG = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              regwrite,
    input  logic [ADDR_W-1:0] rd,
    input  logic [DATA_W-1:0] write_data,
    input  logic [ADDR_W-1:0] rs,
    input  logic [ADDR_W-1:0] rt,
    output logic [DATA_W-1:0] rdata1,
    output logic [DATA_W-1:0] rdata2,
    input  logic              clear_req,
    output logic              clear_busy,
    output logic              clear_done,
    output logic              wr_drop
);
    localparam int DEPTH = 1 << ADDR_W;
    localparam logic [0:0] ST_IDLE  = 1'b0;
    localparam logic [0:0] ST_CLEAR = 1'b1;

    logic [0:0]        state;
    logic [ADDR_W-1:0] clr_cnt;
    logic [DATA_W-1:0] mem [DEPTH];
    logic              clr_last;
    logic              wr_en;
    logic              rd_is_zero;
    logic [DATA_W-1:0] rd_val1;
    logic [DATA_W-1:0] rd_val2;

    assign clear_busy = (state == ST_CLEAR);
    assign clr_last   = (clr_cnt == {ADDR_W{1'b1}});
    assign rd_is_zero = (ZERO_REG != 0) && (rd == '0);
    assign wr_en      = (state == ST_IDLE) && regwrite && !rd_is_zero;

    always_comb begin
        rd_val1 = mem[rs];
        rd_val2 = mem[rt];
        if ((ZERO_REG != 0) && (rs == '0)) rd_val1 = '0;
        if ((ZERO_REG != 0) && (rt == '0)) rd_val2 = '0;
`ifdef REGFILE_BYPASS_EN
        // Forward the value being written so ID never sees a stale WB result
        if (wr_en && (rd == rs)) rd_val1 = write_data;
        if (wr_en && (rd == rt)) rd_val2 = write_data;
`endif
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
        end else if (state == ST_CLEAR) begin
            mem[clr_cnt] <= '0;
        end else if (wr_en) begin
            mem[rd] <= write_data;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= ST_IDLE;
            clr_cnt    <= '0;
            clear_done <= 1'b0;
            wr_drop    <= 1'b0;
        end else begin
            clear_done <= 1'b0;
            wr_drop    <= 1'b0;
            if (state == ST_CLEAR) begin
                wr_drop <= regwrite;
                if (clr_last) begin
                    state      <= ST_IDLE;
                    clr_cnt    <= '0;
                    clear_done <= 1'b1;
                end else begin
                    clr_cnt <= clr_cnt + 1'b1;
                end
            end else if (clear_req) begin
                state   <= ST_CLEAR;
                clr_cnt <= '0;
            end
        end
    end

    // The array is unreadable while the clear engine owns it
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rdata1 <= '0;
            rdata2 <= '0;
        end else if (state == ST_CLEAR) begin
            rdata1 <= '0;
            rdata2 <= '0;
        end else begin
            rdata1 <= rd_val1;
            rdata2 <= rd_val2;
        end
    end
endmodule
